data_memory_initiator: RTL and testbench



---
 rtl/data_memory_pkg.sv | 8 +
 rtl/data_memory_initiator.sv | 90 +++++++++
 tb/tb_data_memory_initiator.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared FSM state encoding and default sizing for the data memory initiator
package data_memory_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
  localparam int MEM_READ_LATENCY = 1;
  localparam int CNT_WIDTH = 3;
endpackage

// File: rtl/data_memory_initiator.sv
// data_memory_initiator: load/store initiator for one synchronous data memory port; core request/response handshakes in, mem_* port out, busy when not IDLE
module data_memory_initiator #(
  parameter int ADDR_WIDTH = data_memory_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = data_memory_pkg::DATA_WIDTH,
  parameter int READ_LATENCY = data_memory_pkg::MEM_READ_LATENCY
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);
  import data_memory_pkg::*;
  if (READ_LATENCY < 1 || READ_LATENCY > 7) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..7");
  end
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(READ_LATENCY - 1);
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic write_q, write_d, rwrite_q, rwrite_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic accept;
  // gated by reset so every output reads 0 while reset is held
  assign req_ready = ~reset & (state_q == IDLE | (state_q == RESP & resp_ready));
  assign accept = req_valid & req_ready;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_write = rwrite_q;
  assign mem_address = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_write_enable = state_q == ISSUE & write_q;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    addr_d = accept ? req_address : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    write_d = accept ? req_write : write_q;
    rdata_d = rdata_q;
    rwrite_d = rwrite_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: state_d = accept ? ISSUE : IDLE;
      ISSUE: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = RESP;
          rdata_d = mem_read_data;
          rwrite_d = write_q;
        end
      end
      RESP: state_d = accept ? ISSUE : resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      rwrite_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      rwrite_q <= rwrite_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_data_memory_initiator.sv
// tb_data_memory_initiator: scoreboard bench for the data memory initiator at read latency 1 and 3
module tb_data_memory_initiator;
  typedef struct packed {logic [15:0] d; logic w;} exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  int checks = 0;
  int errors = 0;
  exp_t q1[$];
  exp_t q3[$];
  logic req_valid = 0, req_write = 0, resp_ready = 0;
  logic [15:0] req_address = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_write, mem_we, busy;
  logic [15:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
  logic req_valid3 = 0, req_write3 = 0, resp_ready3 = 0;
  logic [15:0] req_address3 = 0, req_wdata3 = 0;
  logic req_ready3, resp_valid3, resp_write3, mem_we3, busy3;
  logic [15:0] resp_rdata3, mem_address3, mem_write_data3, mem_read_data3;
  data_memory_initiator dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_address(req_address), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_write(resp_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_we), .mem_read_data(mem_read_data), .busy(busy)
  );
  data_memory_initiator #(.READ_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write3), .req_address(req_address3), .req_wdata(req_wdata3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_rdata(resp_rdata3),
    .resp_write(resp_write3), .mem_address(mem_address3), .mem_write_data(mem_write_data3),
    .mem_write_enable(mem_we3), .mem_read_data(mem_read_data3), .busy(busy3)
  );
  logic [15:0] mem1 [int];
  logic [15:0] mem3 [int];
  logic [15:0] rd1, p0, p1, p2;
  always @(posedge clock) begin
    rd1 <= mem_we ? mem_write_data : (mem1.exists(int'(mem_address)) ? mem1[int'(mem_address)] : 16'h0);
    if (mem_we) mem1[int'(mem_address)] = mem_write_data;
  end
  always @(posedge clock) begin
    p0 <= mem_we3 ? mem_write_data3 : (mem3.exists(int'(mem_address3)) ? mem3[int'(mem_address3)] : 16'h0);
    p1 <= p0;
    p2 <= p1;
    if (mem_we3) mem3[int'(mem_address3)] = mem_write_data3;
  end
  assign mem_read_data = rd1;
  assign mem_read_data3 = p2;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  logic prev_we = 0, prev_we3 = 0;
  always @(negedge clock) begin
    exp_t e;
    if (mem_we) chk("we_single1", {31'b0, prev_we}, 0);
    if (mem_we3) chk("we_single3", {31'b0, prev_we3}, 0);
    prev_we <= mem_we;
    prev_we3 <= mem_we3;
    if (resp_valid && resp_ready) begin
      if (q1.size() == 0) chk("resp1_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        chk("resp1_rdata", {16'b0, resp_rdata}, {16'b0, e.d});
        chk("resp1_write", {31'b0, resp_write}, {31'b0, e.w});
      end
    end
    if (resp_valid3 && resp_ready3) begin
      if (q3.size() == 0) chk("resp3_unexpected", 1, 0);
      else begin
        e = q3.pop_front();
        chk("resp3_rdata", {16'b0, resp_rdata3}, {16'b0, e.d});
        chk("resp3_write", {31'b0, resp_write3}, {31'b0, e.w});
      end
    end
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] e, input bit push);
    req_valid = 1;
    req_write = w;
    req_address = a;
    req_wdata = d;
    if (push) q1.push_back('{d: e, w: w});
  endtask
  task automatic issue3(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] e);
    req_valid3 = 1;
    req_write3 = w;
    req_address3 = a;
    req_wdata3 = d;
    q3.push_back('{d: e, w: w});
  endtask
  initial begin
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    repeat (2) step();
    reset = 0;
    #1;
    chk("post_rst_req_ready", {31'b0, req_ready}, 1);
    chk("post_rst_busy", {31'b0, busy}, 0);
    step();
    // store 0xBEEF to 0x0010
    resp_ready = 1;
    issue(1, 16'h0010, 16'hBEEF, 16'hBEEF, 1);
    step();
    req_valid = 0;
    chk("st_we_n1", {31'b0, mem_we}, 1);
    chk("st_addr_n1", {16'b0, mem_address}, 32'h0010);
    chk("st_wdata_n1", {16'b0, mem_write_data}, 32'hBEEF);
    chk("st_req_ready_n1", {31'b0, req_ready}, 0);
    step();
    chk("st_we_n2", {31'b0, mem_we}, 0);
    chk("st_rv_n2", {31'b0, resp_valid}, 0);
    step();
    chk("st_rv_n3", {31'b0, resp_valid}, 1);
    chk("st_rdata_n3", {16'b0, resp_rdata}, 32'hBEEF);
    chk("st_rw_n3", {31'b0, resp_write}, 1);
    step();
    chk("st_idle_rv", {31'b0, resp_valid}, 0);
    chk("st_idle_ready", {31'b0, req_ready}, 1);
    // loads
    issue(0, 16'h0010, 16'h0000, 16'hBEEF, 1);
    step();
    req_valid = 0;
    chk("ld_we_n1", {31'b0, mem_we}, 0);
    step();
    step();
    chk("ld_rv_n3", {31'b0, resp_valid}, 1);
    chk("ld_rw_n3", {31'b0, resp_write}, 0);
    step();
    issue(0, 16'hFFFF, 16'h1111, 16'h0000, 1);
    step();
    req_valid = 0;
    chk("ldff_addr", {16'b0, mem_address}, 32'hFFFF);
    step();
    step();
    chk("ldff_rv_n3", {31'b0, resp_valid}, 1);
    chk("ldff_rdata", {16'b0, resp_rdata}, 32'h0000);
    step();
    // backpressure with a queued store
    resp_ready = 0;
    issue(0, 16'h0010, 16'h0000, 16'hBEEF, 1);
    step();
    issue(1, 16'h0020, 16'h1234, 16'h1234, 1);
    chk("bp_req_ready_issue", {31'b0, req_ready}, 0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rv", {31'b0, resp_valid}, 1);
      chk("bp_rdata", {16'b0, resp_rdata}, 32'hBEEF);
      chk("bp_req_ready", {31'b0, req_ready}, 0);
      chk("bp_we", {31'b0, mem_we}, 0);
      step();
    end
    resp_ready = 1;
    #1;
    chk("bp_release_ready", {31'b0, req_ready}, 1);
    step();
    req_valid = 0;
    chk("bp_issue_we", {31'b0, mem_we}, 1);
    chk("bp_issue_addr", {16'b0, mem_address}, 32'h0020);
    chk("bp_issue_rv", {31'b0, resp_valid}, 0);
    step();
    step();
    chk("bp_st_rv", {31'b0, resp_valid}, 1);
    chk("bp_st_rdata", {16'b0, resp_rdata}, 32'h1234);
    step();
    // back-to-back store then load, latency 1
    issue(1, 16'h0030, 16'h5A5A, 16'h5A5A, 1);
    step();
    issue(0, 16'h0030, 16'h0000, 16'h5A5A, 1);
    chk("b2b_we_n1", {31'b0, mem_we}, 1);
    step();
    chk("b2b_rv_n2", {31'b0, resp_valid}, 0);
    step();
    chk("b2b_rv_n3", {31'b0, resp_valid}, 1);
    chk("b2b_ready_n3", {31'b0, req_ready}, 1);
    step();
    req_valid = 0;
    chk("b2b_issue_we", {31'b0, mem_we}, 0);
    chk("b2b_issue_busy", {31'b0, busy}, 1);
    chk("b2b_issue_rv", {31'b0, resp_valid}, 0);
    chk("b2b_issue_addr", {16'b0, mem_address}, 32'h0030);
    step();
    step();
    chk("b2b_ld_rv", {31'b0, resp_valid}, 1);
    chk("b2b_ld_rdata", {16'b0, resp_rdata}, 32'h5A5A);
    step();
    // back-to-back at latency 3
    resp_ready3 = 1;
    issue3(1, 16'h0040, 16'h0F0F, 16'h0F0F);
    step();
    issue3(0, 16'h0040, 16'h0000, 16'h0F0F);
    chk("l3_we_n1", {31'b0, mem_we3}, 1);
    step();
    step();
    step();
    chk("l3_rv_n4", {31'b0, resp_valid3}, 0);
    step();
    chk("l3_rv_n5", {31'b0, resp_valid3}, 1);
    chk("l3_rdata_n5", {16'b0, resp_rdata3}, 32'h0F0F);
    chk("l3_ready_n5", {31'b0, req_ready3}, 1);
    step();
    req_valid3 = 0;
    chk("l3_ld_we", {31'b0, mem_we3}, 0);
    chk("l3_ld_addr", {16'b0, mem_address3}, 32'h0040);
    step();
    step();
    step();
    chk("l3_ld_rv_m4", {31'b0, resp_valid3}, 0);
    step();
    chk("l3_ld_rv_m5", {31'b0, resp_valid3}, 1);
    chk("l3_ld_rdata", {16'b0, resp_rdata3}, 32'h0F0F);
    chk("l3_ld_rw", {31'b0, resp_write3}, 0);
    step();
    // reset during WAIT of a load: response is dropped
    issue(0, 16'h0010, 16'h0000, 16'h0000, 0);
    step();
    req_valid = 0;
    step();
    chk("r6_wait_busy", {31'b0, busy}, 1);
    reset = 1;
    #1;
    chk("r6_busy", {31'b0, busy}, 0);
    chk("r6_rv", {31'b0, resp_valid}, 0);
    chk("r6_addr", {16'b0, mem_address}, 0);
    chk("r6_rdata", {16'b0, resp_rdata}, 0);
    chk("r6_req_ready", {31'b0, req_ready}, 0);
    step();
    step();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      chk("r6_no_rv", {31'b0, resp_valid}, 0);
      chk("r6_idle", {31'b0, busy}, 0);
      step();
    end
    issue(1, 16'h0050, 16'hCAFE, 16'hCAFE, 1);
    step();
    req_valid = 0;
    chk("r6_next_we", {31'b0, mem_we}, 1);
    step();
    step();
    chk("r6_next_rv", {31'b0, resp_valid}, 1);
    chk("r6_next_rdata", {16'b0, resp_rdata}, 32'hCAFE);
    step();
    step();
    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
